// File: rtl/popcorn_seq.sv
// popcorn_seq: microcoded control sequencer for the popcorn 8-bit CPU.
// Decodes the state register and the latched opcode into datapath enables,
// and drives three byte-latch strobes from falling-edge flops.
module popcorn_seq (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] reg_opl,
  input  logic [2:0] reg_flag,
  output logic       w_opl,
  output logic       w_oplo,
  output logic       w_ophi,
  output logic       w_acc,
  output logic       w_ax,
  output logic       w_bx,
  output logic       w_p,
  output logic       w_flag,
  output logic       flag_mux,
  output logic [2:0] bbus_mux,
  output logic [3:0] alu_func,
  output logic       w_pc,
  output logic       pc_mux,
  output logic       w_sp,
  output logic       sp_mux,
  output logic [1:0] addx_mux,
  output logic       data_bus_wr,
  output logic       code_wr_l,
  output logic       halted
);

  typedef enum logic [3:0] {
    StFetch, StOplo, StOphi, StEx, StEx2,
    StC1, StC2, StC3, StC4, StC5,
    StR1, StR2, StR3, StR4, StR5,
    StHalt
  } state_e;

  localparam logic [2:0] ClsAluReg = 3'b001;
  localparam logic [2:0] ClsAluImm = 3'b010;
  localparam logic [2:0] ClsMov    = 3'b011;
  localparam logic [2:0] ClsLoad   = 3'b100;
  localparam logic [2:0] ClsStore  = 3'b101;
  localparam logic [2:0] ClsJump   = 3'b110;
  localparam logic [2:0] ClsSys    = 3'b111;

  state_e     state_q, state_d;
  logic [2:0] opc_cls;
  logic [1:0] opc_sub;
  logic [2:0] reg_bsel;
  logic       jump_take;
  // Strobe order in these vectors: {opl, oplo, ophi}.
  logic [2:0] strb_req;
  logic [2:0] strb_set_q;
  logic [2:0] strb_clr_q;

  assign opc_cls = reg_opl[7:5];
  assign opc_sub = reg_opl[1:0];

  // A strobe is high while its set and clear flops disagree: set at the falling
  // edge, cleared by the following rising edge, so one clean pulse per state.
  assign {w_opl, w_oplo, w_ophi} = strb_set_q ^ strb_clr_q;

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= StFetch;
    else          state_q <= state_d;
  end

  // Falling-edge half of the strobe pulse generators.
  always_ff @(negedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) strb_set_q <= 3'b000;
    else          strb_set_q <= strb_clr_q ^ strb_req;
  end

  // Rising-edge half: re-aligns clear with set, ending any pulse.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) strb_clr_q <= 3'b000;
    else          strb_clr_q <= strb_set_q;
  end

  // Register-source B-bus select and jump condition from the opcode.
  always_comb begin
    reg_bsel = 3'b001;
    case (reg_opl[4:3])
      2'b01:   reg_bsel = 3'b010;
      2'b10:   reg_bsel = 3'b101;
      default: reg_bsel = 3'b001;
    endcase
    jump_take = 1'b1;
    case (opc_sub)
      2'b01:   jump_take = reg_flag[2];
      2'b10:   jump_take = reg_flag[0];
      2'b11:   jump_take = reg_flag[1];
      default: jump_take = 1'b1;
    endcase
  end

  // Next-state: instruction length and extra states follow the opcode class.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        case (opc_cls)
          ClsAluImm, ClsLoad, ClsStore, ClsJump: state_d = StOplo;
          ClsSys: begin
            case (opc_sub)
              2'b00:   state_d = StOplo;
              2'b01:   state_d = StR1;
              2'b10:   state_d = StHalt;
              default: state_d = StEx;
            endcase
          end
          default: state_d = StEx;
        endcase
      end
      StOplo:  state_d = (opc_cls == ClsAluImm) ? StEx : StOphi;
      // Only CALL reaches OPHI with the system class.
      StOphi:  state_d = (opc_cls == ClsSys) ? StC1 : StEx;
      StEx:    state_d = (opc_cls == ClsLoad) ? StEx2 : StFetch;
      StEx2:   state_d = StFetch;
      StC1:    state_d = StC2;
      StC2:    state_d = StC3;
      StC3:    state_d = StC4;
      StC4:    state_d = StC5;
      StC5:    state_d = StFetch;
      StR1:    state_d = StR2;
      StR2:    state_d = StR3;
      StR3:    state_d = StR4;
      StR4:    state_d = StR5;
      StR5:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Output decode: idle values first, each state overrides only what it uses.
  // Held idle while reset is asserted even though the state reads FETCH.
  always_comb begin
    w_acc       = 1'b1;
    w_ax        = 1'b1;
    w_bx        = 1'b1;
    w_p         = 1'b1;
    w_flag      = 1'b1;
    flag_mux    = 1'b1;
    bbus_mux    = 3'b000;
    alu_func    = 4'b1001;
    w_pc        = 1'b1;
    pc_mux      = 1'b1;
    w_sp        = 1'b1;
    sp_mux      = 1'b0;
    addx_mux    = 2'b01;
    data_bus_wr = 1'b1;
    code_wr_l   = 1'b1;
    halted      = 1'b0;
    strb_req    = 3'b000;
    if (sys_rst) begin
      case (state_q)
        StFetch: begin strb_req = 3'b100; w_pc = 1'b0; end
        StOplo:  begin strb_req = 3'b010; w_pc = 1'b0; end
        StOphi:  begin strb_req = 3'b001; w_pc = 1'b0; end
        StEx: begin
          case (opc_cls)
            ClsAluReg, ClsAluImm: begin
              alu_func = {1'b0, reg_opl[2:0]};
              bbus_mux = (opc_cls == ClsAluImm) ? 3'b110 : reg_bsel;
              w_acc    = 1'b0;
              w_flag   = 1'b0;
              flag_mux = 1'b1;
            end
            ClsMov: begin
              case (opc_sub)
                2'b00:   w_ax = 1'b0;
                2'b01:   w_bx = 1'b0;
                2'b10:   w_p  = 1'b0;
                default: ;
              endcase
            end
            ClsLoad: begin addx_mux = 2'b00; strb_req = 3'b010; end
            ClsStore: begin
              addx_mux    = 2'b00;
              data_bus_wr = 1'b0;
              code_wr_l   = 1'b0;
            end
            ClsJump: if (jump_take) begin w_pc = 1'b0; pc_mux = 1'b0; end
            default: ;
          endcase
        end
        StEx2: begin bbus_mux = 3'b110; alu_func = 4'b1000; w_acc = 1'b0; end
        StC1, StC3: begin
          addx_mux    = 2'b10;
          bbus_mux    = (state_q == StC1) ? 3'b011 : 3'b100;
          alu_func    = 4'b1000;
          data_bus_wr = 1'b0;
          code_wr_l   = 1'b0;
        end
        StC2, StC4: begin w_sp = 1'b0; sp_mux = 1'b1; end
        StR1, StR3: begin w_sp = 1'b0; sp_mux = 1'b0; end
        StR2:       begin addx_mux = 2'b10; strb_req = 3'b001; end
        StR4:       begin addx_mux = 2'b10; strb_req = 3'b010; end
        StC5, StR5: begin w_pc = 1'b0; pc_mux = 1'b0; end
        StHalt:     halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_popcorn_seq.sv
// Bench for popcorn_seq: a small behavioural datapath and memory close the loop
// around the sequencer; instruction results are scored against expected records.
module tb_popcorn_seq;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic [7:0] reg_opl;
  logic [2:0] reg_flag;
  logic       w_opl, w_oplo, w_ophi, w_acc, w_ax, w_bx, w_p, w_flag, flag_mux;
  logic [2:0] bbus_mux;
  logic [3:0] alu_func;
  logic       w_pc, pc_mux, w_sp, sp_mux;
  logic [1:0] addx_mux;
  logic       data_bus_wr, code_wr_l, halted;

  popcorn_seq dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .reg_opl(reg_opl), .reg_flag(reg_flag),
    .w_opl(w_opl), .w_oplo(w_oplo), .w_ophi(w_ophi), .w_acc(w_acc), .w_ax(w_ax),
    .w_bx(w_bx), .w_p(w_p), .w_flag(w_flag), .flag_mux(flag_mux), .bbus_mux(bbus_mux),
    .alu_func(alu_func), .w_pc(w_pc), .pc_mux(pc_mux), .w_sp(w_sp), .sp_mux(sp_mux),
    .addx_mux(addx_mux), .data_bus_wr(data_bus_wr), .code_wr_l(code_wr_l), .halted(halted)
  );

  always #5 sys_clk = ~sys_clk;

  // Idle output pattern, halted = 0.
  localparam logic [24:0] IDLE = {3'b000, 5'b11111, 1'b1, 3'b000, 4'b1001,
                                  1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
  logic [24:0] outs;
  assign outs = {w_opl, w_oplo, w_ophi, w_acc, w_ax, w_bx, w_p, w_flag, flag_mux, bbus_mux,
                 alu_func, w_pc, pc_mux, w_sp, sp_mux, addx_mux, data_bus_wr, code_wr_l, halted};

  // ---------------- datapath model ----------------
  logic [7:0]  image [4096];
  logic [7:0]  mem   [4096];
  logic [11:0] pc, sp, init_sp, addr;
  logic [7:0]  acc, ax, bx, pr, init_acc, init_ax, init_bx, b_val;
  logic [2:0]  flags, init_flags;
  logic [8:0]  alu_r;
  logic [7:0]  opl = 8'h00, oplo = 8'h00, ophi = 8'h00;

  assign reg_opl  = opl;
  assign reg_flag = flags;

  always_comb begin
    addr = pc;
    if (addx_mux == 2'b00)      addr = {ophi[3:0], oplo};
    else if (addx_mux == 2'b10) addr = sp;
    b_val = 8'h00;
    case (bbus_mux)
      3'b001:  b_val = ax;
      3'b010:  b_val = bx;
      3'b011:  b_val = pc[7:0];
      3'b100:  b_val = {flags, 1'b0, pc[11:8]};
      3'b110:  b_val = oplo;
      default: b_val = 8'h00;
    endcase
    case (alu_func)
      4'b0000: alu_r = {1'b0, acc} + {1'b0, b_val};
      4'b1000: alu_r = {1'b0, b_val};
      default: alu_r = {1'b0, acc};
    endcase
  end

  always @(posedge w_opl)  opl  <= mem[addr];
  always @(posedge w_oplo) oplo <= mem[addr];
  always @(posedge w_ophi) ophi <= mem[addr];

  always @(posedge sys_clk) begin
    if (!sys_rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= image[i];
      pc <= 12'h000; sp <= init_sp; acc <= init_acc; ax <= init_ax; bx <= init_bx;
      flags <= init_flags; pr <= 8'h00;
    end else begin
      if (!w_acc) acc <= alu_r[7:0];
      if (!w_ax)  ax  <= alu_r[7:0];
      if (!w_bx)  bx  <= alu_r[7:0];
      if (!w_p)   pr  <= alu_r[7:0];
      if (!w_flag && flag_mux)
        flags <= {alu_r[8], ~alu_r[7] & (alu_r[7:0] != 8'h00), alu_r[7:0] == 8'h00};
      if (!w_pc) pc <= pc_mux ? pc + 12'h001 : {ophi[3:0], oplo};
      if (!w_sp) sp <= sp_mux ? sp - 12'h001 : sp + 12'h001;
      if (!code_wr_l && !data_bus_wr) mem[addr] <= alu_r[7:0];
    end
  end

  // Free-running event counters; the test takes differences.
  int strobe_cnt = 0, wr_cnt = 0, viol_cnt = 0;
  always @(negedge sys_clk) begin
    #1;
    if (w_opl | w_oplo | w_ophi) strobe_cnt <= strobe_cnt + 1;
    if (!code_wr_l) wr_cnt <= wr_cnt + 1;
    if ((w_opl | w_oplo | w_ophi) && !data_bus_wr) viol_cnt <= viol_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Cycles until the next opcode strobe; -1 if none within the budget.
  task automatic wait_fetch(output int len);
    len = 0;
    do begin
      @(negedge sys_clk); #1;
      len++;
    end while (!w_opl && len < 300);
    if (!w_opl) len = -1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
  endtask

  task automatic clear_image();
    for (int i = 0; i < 4096; i++) image[i] = 8'h00;
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [11:0] daddr;
    logic [7:0]  dval, acc, ax, bx;
    logic [2:0]  flg;
    int          len;
    logic [11:0] e_pc;
    logic [7:0]  e_acc, e_ax, e_bx;
    logic [2:0]  e_flg;
    logic [11:0] caddr;
    logic [7:0]  cval;
  } vec_t;

  vec_t vecs[15];
  vec_t exp_q[$];

  initial begin
    vec_t e;
    int   len, w0, s0;
    //          b0     b1     b2     daddr    dval   acc    ax     bx     flg
    //          len pc       acc    ax     bx     flg     caddr    cval
    vecs[0]  = '{8'h20, 8'h00, 8'h00, 12'h0F0, 8'h00, 8'h04, 8'h03, 8'h00, 3'b000,
                 2, 12'h001, 8'h07, 8'h03, 8'h00, 3'b010, 12'h000, 8'h20};
    vecs[1]  = '{8'h40, 8'h05, 8'h00, 12'h0F0, 8'h00, 8'hFF, 8'h00, 8'h00, 3'b000,
                 3, 12'h002, 8'h04, 8'h00, 8'h00, 3'b110, 12'h001, 8'h05};
    vecs[2]  = '{8'h00, 8'h00, 8'h00, 12'h0F0, 8'h00, 8'h11, 8'h22, 8'h33, 3'b101,
                 2, 12'h001, 8'h11, 8'h22, 8'h33, 3'b101, 12'h000, 8'h00};
    vecs[3]  = '{8'h60, 8'h00, 8'h00, 12'h0F0, 8'h00, 8'h5A, 8'h00, 8'h00, 3'b000,
                 2, 12'h001, 8'h5A, 8'h5A, 8'h00, 3'b000, 12'h000, 8'h60};
    vecs[4]  = '{8'h61, 8'h00, 8'h00, 12'h0F0, 8'h00, 8'h5A, 8'h00, 8'h00, 3'b000,
                 2, 12'h001, 8'h5A, 8'h00, 8'h5A, 3'b000, 12'h000, 8'h61};
    vecs[5]  = '{8'h28, 8'h00, 8'h00, 12'h0F0, 8'h00, 8'h01, 8'h09, 8'h02, 3'b000,
                 2, 12'h001, 8'h03, 8'h09, 8'h02, 3'b010, 12'h000, 8'h28};
    vecs[6]  = '{8'h80, 8'h50, 8'h00, 12'h050, 8'h77, 8'h00, 8'h00, 8'h00, 3'b000,
                 5, 12'h003, 8'h77, 8'h00, 8'h00, 3'b000, 12'h050, 8'h77};
    vecs[7]  = '{8'hA0, 8'h60, 8'h00, 12'h0F0, 8'h00, 8'h99, 8'h00, 8'h00, 3'b000,
                 4, 12'h003, 8'h99, 8'h00, 8'h00, 3'b000, 12'h060, 8'h99};
    vecs[8]  = '{8'hC2, 8'h34, 8'h01, 12'h0F0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000,
                 4, 12'h003, 8'h00, 8'h00, 8'h00, 3'b000, 12'h000, 8'hC2};
    vecs[9]  = '{8'hC2, 8'h34, 8'h01, 12'h0F0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001,
                 4, 12'h134, 8'h00, 8'h00, 8'h00, 3'b001, 12'h000, 8'hC2};
    vecs[10] = '{8'hC0, 8'h00, 8'h08, 12'h0F0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000,
                 4, 12'h800, 8'h00, 8'h00, 8'h00, 3'b000, 12'h000, 8'hC0};
    vecs[11] = '{8'hC1, 8'h00, 8'h08, 12'h0F0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b011,
                 4, 12'h003, 8'h00, 8'h00, 8'h00, 3'b011, 12'h000, 8'hC1};
    vecs[12] = '{8'hC1, 8'h00, 8'h08, 12'h0F0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b100,
                 4, 12'h800, 8'h00, 8'h00, 8'h00, 3'b100, 12'h000, 8'hC1};
    vecs[13] = '{8'hC3, 8'h00, 8'h08, 12'h0F0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010,
                 4, 12'h800, 8'h00, 8'h00, 8'h00, 3'b010, 12'h000, 8'hC3};
    vecs[14] = '{8'hE3, 8'h00, 8'h00, 12'h0F0, 8'h00, 8'h42, 8'h00, 8'h00, 3'b000,
                 2, 12'h001, 8'h42, 8'h00, 8'h00, 3'b000, 12'h000, 8'hE3};

    init_sp = 12'hFFF; init_acc = 8'h00; init_ax = 8'h00; init_bx = 8'h00; init_flags = 3'b000;
    clear_image();

    // Power-on reset: outputs idle.
    repeat (2) @(posedge sys_clk);
    #1 chk("reset_idle", int'(outs), int'(IDLE));

    // Single-instruction vectors, scored when the next fetch begins.
    for (int i = 0; i < 15; i++) begin
      sys_rst = 1'b0;
      clear_image();
      image[0] = vecs[i].b0; image[1] = vecs[i].b1; image[2] = vecs[i].b2;
      image[vecs[i].daddr] = vecs[i].dval;
      init_acc = vecs[i].acc; init_ax = vecs[i].ax; init_bx = vecs[i].bx;
      init_flags = vecs[i].flg;
      exp_q.push_back(vecs[i]);
      do_reset();
      wait_fetch(len);
      wait_fetch(len);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_cycles", i), len, e.len);
      chk($sformatf("v%0d_pc", i), int'(pc), int'(e.e_pc));
      chk($sformatf("v%0d_acc", i), int'(acc), int'(e.e_acc));
      chk($sformatf("v%0d_ax", i), int'(ax), int'(e.e_ax));
      chk($sformatf("v%0d_bx", i), int'(bx), int'(e.e_bx));
      chk($sformatf("v%0d_flags", i), int'(flags), int'(e.e_flg));
      chk($sformatf("v%0d_mem", i), int'(mem[e.caddr]), int'(e.cval));
    end

    // CALL at 0x010 then RET at 0x200.
    sys_rst = 1'b0;
    clear_image();
    image[12'h000] = 8'hC0; image[12'h001] = 8'h10; image[12'h002] = 8'h00;
    image[12'h010] = 8'hE0; image[12'h011] = 8'h00; image[12'h012] = 8'h02;
    image[12'h200] = 8'hE1;
    init_sp = 12'hFFF; init_flags = 3'b010; init_acc = 8'h00;
    do_reset();
    wait_fetch(len);
    wait_fetch(len);
    chk("call_jmp_cycles", len, 4);
    wait_fetch(len);
    chk("call_cycles", len, 8);
    chk("call_pc", int'(pc), 'h200);
    chk("call_sp", int'(sp), 'hFFD);
    chk("call_mem_fff", int'(mem[12'hFFF]), 'h13);
    chk("call_mem_ffe", int'(mem[12'hFFE]), 'h40);
    wait_fetch(len);
    chk("ret_cycles", len, 6);
    chk("ret_pc", int'(pc), 'h013);
    chk("ret_sp", int'(sp), 'hFFF);

    // Reset asserted in the middle of C3 of the same CALL.
    do_reset();
    wait_fetch(len);
    wait_fetch(len);
    w0 = wr_cnt;
    repeat (5) @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    #1 chk("c3_reset_idle", int'(outs), int'(IDLE));
    repeat (2) @(posedge sys_clk);
    chk("c3_reset_writes", wr_cnt - w0, 1);
    #1 sys_rst = 1'b1;
    wait_fetch(len);
    chk("c3_refetch_pc", int'(pc), 0);
    chk("c3_refetch_op", int'(opl), 'hC0);

    // HALT holds for 100 cycles with no strobes and a frozen PC.
    sys_rst = 1'b0;
    clear_image();
    image[0] = 8'hE2;
    do_reset();
    wait_fetch(len);
    @(posedge sys_clk);
    s0 = strobe_cnt;
    repeat (100) @(posedge sys_clk);
    #1;
    chk("halt_outs", int'(outs), int'(IDLE | 25'd1));
    chk("halt_pc", int'(pc), 1);
    chk("halt_strobes", strobe_cnt - s0, 0);

    chk("no_dbus_during_strobe", viol_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
